// File: rtl/layer_compositor.sv
// layer_compositor: two-layer line compositor with horizontal scaling and border window.
// Latency: pixel_req in cycle n -> pix_idx/pix_valid in cycle n+2, one pixel per cycle.
// Backpressure: none; pixel_req gaps hold the counters and produce pix_valid gaps.
//
// Ports:
//   clk, rst                      pixel clock, asynchronous active-high reset
//   start_of_line, pixel_req      video timing (line start pulse, per-pixel request)
//   regs_addr/wrdata/write/rddata register access; read data is combinational
//   linebuf_rdidx                 shared read index for both layer line buffers
//   layer1_rddata, layer2_rddata  line buffer data, one cycle after linebuf_rdidx
//   pix_idx, pix_valid            composited palette index and its strobe
module layer_compositor (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_of_line,
  input  logic       pixel_req,
  input  logic [2:0] regs_addr,
  input  logic [7:0] regs_wrdata,
  input  logic       regs_write,
  output logic [7:0] regs_rddata,
  output logic [9:0] linebuf_rdidx,
  input  logic [7:0] layer1_rddata,
  input  logic [7:0] layer2_rddata,
  output logic [7:0] pix_idx,
  output logic       pix_valid
);

  // Accumulator ceiling: integer part 639, fraction 0.
  localparam logic [16:0] ACC_MAX = {10'd639, 7'd0};

  logic [1:0]  ctrl_en;
  logic [7:0]  hscale;
  logic [7:0]  border;
  logic [7:0]  hstart;
  logic [7:0]  hstop;

  logic [9:0]  x_cnt;
  logic [16:0] acc;
  logic [9:0]  x_cur;
  logic [16:0] acc_cur;
  logic        active;
  logic [17:0] acc_sum;
  logic [16:0] acc_nxt;

  logic        vld1;
  logic        act1;
  logic [1:0]  en1;
  logic [7:0]  sel_pix;

  // Register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en <= 2'b11;
      hscale  <= 8'h80;
      border  <= 8'h00;
      hstart  <= 8'h00;
      hstop   <= 8'hA0;
    end else if (regs_write) begin
      case (regs_addr)
        3'd0:    ctrl_en <= regs_wrdata[1:0];
        3'd1:    hscale  <= regs_wrdata;
        3'd2:    border  <= regs_wrdata;
        3'd3:    hstart  <= regs_wrdata;
        3'd4:    hstop   <= regs_wrdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    regs_rddata = 8'h00;
    case (regs_addr)
      3'd0:    regs_rddata = {6'd0, ctrl_en};
      3'd1:    regs_rddata = hscale;
      3'd2:    regs_rddata = border;
      3'd3:    regs_rddata = hstart;
      3'd4:    regs_rddata = hstop;
      default: regs_rddata = 8'h00;
    endcase
  end

  // A start_of_line coinciding with pixel_req makes this pixel see a fresh line.
  assign x_cur   = start_of_line ? 10'd0 : x_cnt;
  assign acc_cur = start_of_line ? 17'd0 : acc;

  // An empty window (hstop <= hstart) falls out of this compare naturally.
  assign active = (x_cur >= {hstart, 2'b00}) && (x_cur < {hstop, 2'b00});

  assign acc_sum = {1'b0, acc_cur} + {10'd0, hscale};
  assign acc_nxt = (acc_sum > {1'b0, ACC_MAX}) ? ACC_MAX : acc_sum[16:0];

  assign linebuf_rdidx = acc_cur[16:7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= 10'd0;
      acc   <= 17'd0;
    end else if (pixel_req) begin
      x_cnt <= (x_cur == 10'd1023) ? x_cur : x_cur + 10'd1;
      acc   <= active ? acc_nxt : acc_cur;
    end else if (start_of_line) begin
      x_cnt <= 10'd0;
      acc   <= 17'd0;
    end
  end

  // Stage 1: flags travel alongside the line buffer read so that register
  // writes after the request do not affect a pixel already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1 <= 1'b0;
      act1 <= 1'b0;
      en1  <= 2'b00;
    end else begin
      vld1 <= pixel_req;
      act1 <= active;
      en1  <= ctrl_en;
    end
  end

  always_comb begin
    sel_pix = 8'h00;
    if (!act1)
      sel_pix = border;
    else if (en1[1] && (layer2_rddata != 8'h00))
      sel_pix = layer2_rddata;
    else if (en1[0] && (layer1_rddata != 8'h00))
      sel_pix = layer1_rddata;
  end

  // Stage 2: output registers; pix_idx holds its last value between pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_idx   <= 8'h00;
    end else begin
      pix_valid <= vld1;
      if (vld1)
        pix_idx <= sel_pix;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

  logic       clk;
  logic       rst;
  logic       start_of_line;
  logic       pixel_req;
  logic [2:0] regs_addr;
  logic [7:0] regs_wrdata;
  logic       regs_write;
  logic [7:0] regs_rddata;
  logic [9:0] linebuf_rdidx;
  logic [7:0] layer1_rddata;
  logic [7:0] layer2_rddata;
  logic [7:0] pix_idx;
  logic       pix_valid;

  int checks = 0;
  int passed = 0;

  // Line buffer model: layer1 returns the index LSBs or a constant.
  logic       l1_idx_mode;
  logic [7:0] l1_val;
  logic [7:0] l2_val;

  logic [9:0] cap_rdidx [0:1023];
  logic [7:0] cap_pix   [0:1023];
  logic       cap_vld   [0:1023];
  logic       tail_vld;

  layer_compositor dut (
    .clk           (clk),
    .rst           (rst),
    .start_of_line (start_of_line),
    .pixel_req     (pixel_req),
    .regs_addr     (regs_addr),
    .regs_wrdata   (regs_wrdata),
    .regs_write    (regs_write),
    .regs_rddata   (regs_rddata),
    .linebuf_rdidx (linebuf_rdidx),
    .layer1_rddata (layer1_rddata),
    .layer2_rddata (layer2_rddata),
    .pix_idx       (pix_idx),
    .pix_valid     (pix_valid)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) begin
    layer1_rddata <= l1_idx_mode ? linebuf_rdidx[7:0] : l1_val;
    layer2_rddata <= l2_val;
  end

  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    regs_addr   = a;
    regs_wrdata = d;
    regs_write  = 1'b1;
    @(negedge clk);
    regs_write  = 1'b0;
  endtask

  task automatic sol_pulse();
    @(negedge clk);
    start_of_line = 1'b1;
    @(negedge clk);
    start_of_line = 1'b0;
  endtask

  // Issues n back-to-back pixel requests and captures rdidx per request and
  // the output two cycles later; tail_vld is the cycle after the last pixel.
  task automatic drive_line(input int n, input bit coincident);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        cap_vld[i-2] = pix_valid;
        cap_pix[i-2] = pix_idx;
      end
      pixel_req     = (i < n);
      start_of_line = coincident && (i == 0);
      #1;
      if (i < n) cap_rdidx[i] = linebuf_rdidx;
    end
    @(negedge clk);
    tail_vld      = pix_valid;
    pixel_req     = 1'b0;
    start_of_line = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_r [0:7];
    exp_r[0] = 8'h03; exp_r[1] = 8'h80; exp_r[2] = 8'h00; exp_r[3] = 8'h00;
    exp_r[4] = 8'hA0; exp_r[5] = 8'h00; exp_r[6] = 8'h00; exp_r[7] = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pix_valid !== 1'b0) $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); else passed++;
    checks++; if (pix_idx !== 8'h00) $display("FAIL reset_pix_idx: got %h expected 00", pix_idx); else passed++;
    checks++; if (linebuf_rdidx !== 10'd0) $display("FAIL reset_rdidx: got %0d expected 0", linebuf_rdidx); else passed++;
    for (int a = 0; a < 8; a++) begin
      regs_addr = 3'(a);
      #1;
      checks++; if (regs_rddata !== exp_r[a]) $display("FAIL reset_reg[%0d]: got %h expected %h", a, regs_rddata, exp_r[a]); else passed++;
    end
    @(negedge clk);
    rst = 1'b0;
    // Unmapped writes are ignored; CTRL upper bits read as zero.
    reg_write(3'd5, 8'hFF);
    regs_addr = 3'd5; #1;
    checks++; if (regs_rddata !== 8'h00) $display("FAIL unmapped_write: got %h expected 00", regs_rddata); else passed++;
    reg_write(3'd0, 8'hFF);
    regs_addr = 3'd0; #1;
    checks++; if (regs_rddata !== 8'h03) $display("FAIL ctrl_upper_bits: got %h expected 03", regs_rddata); else passed++;
  endtask

  task automatic test_defaults();
    l1_idx_mode = 1'b1; l2_val = 8'h00;
    sol_pulse();
    drive_line(640, 1'b0);
    for (int i = 0; i < 640; i++) begin
      checks++; if (cap_rdidx[i] !== 10'(i)) $display("FAIL default_rdidx[%0d]: got %0d expected %0d", i, cap_rdidx[i], i); else passed++;
      checks++; if (cap_vld[i] !== 1'b1) $display("FAIL default_vld[%0d]: got %b expected 1", i, cap_vld[i]); else passed++;
      checks++; if (cap_pix[i] !== 8'(i)) $display("FAIL default_pix[%0d]: got %h expected %h", i, cap_pix[i], 8'(i)); else passed++;
    end
    checks++; if (tail_vld !== 1'b0) $display("FAIL default_tail_vld: got %b expected 0", tail_vld); else passed++;
  endtask

  task automatic test_priority();
    logic [7:0] c_ctrl [0:4];
    logic [7:0] c_l1   [0:4];
    logic [7:0] c_l2   [0:4];
    logic [7:0] c_exp  [0:4];
    c_ctrl[0] = 8'h03; c_l1[0] = 8'h11; c_l2[0] = 8'h22; c_exp[0] = 8'h22;
    c_ctrl[1] = 8'h03; c_l1[1] = 8'h11; c_l2[1] = 8'h00; c_exp[1] = 8'h11;
    c_ctrl[2] = 8'h01; c_l1[2] = 8'h11; c_l2[2] = 8'h22; c_exp[2] = 8'h11;
    c_ctrl[3] = 8'h00; c_l1[3] = 8'h11; c_l2[3] = 8'h22; c_exp[3] = 8'h00;
    c_ctrl[4] = 8'h02; c_l1[4] = 8'h11; c_l2[4] = 8'h00; c_exp[4] = 8'h00;
    l1_idx_mode = 1'b0;
    for (int c = 0; c < 5; c++) begin
      reg_write(3'd0, c_ctrl[c]);
      l1_val = c_l1[c];
      l2_val = c_l2[c];
      sol_pulse();
      drive_line(3, 1'b0);
      for (int i = 0; i < 3; i++) begin
        checks++; if (cap_pix[i] !== c_exp[c]) $display("FAIL priority_case%0d_pix[%0d]: got %h expected %h", c, i, cap_pix[i], c_exp[c]); else passed++;
      end
    end
    reg_write(3'd0, 8'h03);
    l1_idx_mode = 1'b1; l2_val = 8'h00;
  endtask

  task automatic test_border();
    logic [9:0] e_idx;
    logic [7:0] e_pix;
    reg_write(3'd3, 8'h04);
    reg_write(3'd4, 8'h9C);
    reg_write(3'd2, 8'h5A);
    sol_pulse();
    drive_line(640, 1'b0);
    for (int x = 0; x < 640; x++) begin
      if (x < 16)       e_idx = 10'd0;
      else if (x < 624) e_idx = 10'(x - 16);
      else              e_idx = 10'd608;
      e_pix = (x < 16 || x >= 624) ? 8'h5A : e_idx[7:0];
      checks++; if (cap_rdidx[x] !== e_idx) $display("FAIL border_rdidx[%0d]: got %0d expected %0d", x, cap_rdidx[x], e_idx); else passed++;
      checks++; if (cap_pix[x] !== e_pix) $display("FAIL border_pix[%0d]: got %h expected %h", x, cap_pix[x], e_pix); else passed++;
    end
    reg_write(3'd3, 8'h00);
    reg_write(3'd4, 8'hA0);
    reg_write(3'd2, 8'h00);
  endtask

  task automatic test_scaling();
    int a;
    reg_write(3'd1, 8'h40);
    sol_pulse();
    drive_line(640, 1'b0);
    for (int i = 0; i < 640; i++) begin
      checks++; if (cap_rdidx[i] !== 10'(i / 2)) $display("FAIL scale40_rdidx[%0d]: got %0d expected %0d", i, cap_rdidx[i], i / 2); else passed++;
    end
    reg_write(3'd1, 8'hFF);
    sol_pulse();
    drive_line(640, 1'b0);
    for (int i = 0; i < 640; i++) begin
      a = i * 255;
      if (a > 81792) a = 81792;
      checks++; if (cap_rdidx[i] !== 10'(a >> 7)) $display("FAIL scaleFF_rdidx[%0d]: got %0d expected %0d", i, cap_rdidx[i], a >> 7); else passed++;
      checks++; if (cap_pix[i] !== 8'(a >> 7)) $display("FAIL scaleFF_pix[%0d]: got %h expected %h", i, cap_pix[i], 8'(a >> 7)); else passed++;
    end
    checks++; if (cap_rdidx[639] !== 10'd639) $display("FAIL scaleFF_saturate: got %0d expected 639", cap_rdidx[639]); else passed++;
    reg_write(3'd1, 8'h80);
  endtask

  task automatic test_coincident();
    // Counters are left mid-line / saturated by the previous test.
    drive_line(4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_rdidx[i] !== 10'(i)) $display("FAIL coincident_rdidx[%0d]: got %0d expected %0d", i, cap_rdidx[i], i); else passed++;
      checks++; if (cap_pix[i] !== 8'(i)) $display("FAIL coincident_pix[%0d]: got %h expected %h", i, cap_pix[i], 8'(i)); else passed++;
    end
  endtask

  task automatic test_gaps();
    logic [0:7] pat;
    int         req_k [0:7];
    int         k;
    pat = 8'b1011_0010;
    k = 0;
    sol_pulse();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++; if (pix_valid !== pat[i-2]) $display("FAIL gaps_vld[%0d]: got %b expected %b", i - 2, pix_valid, pat[i-2]); else passed++;
        if (pat[i-2]) begin
          checks++; if (pix_idx !== 8'(req_k[i-2])) $display("FAIL gaps_pix[%0d]: got %h expected %h", i - 2, pix_idx, 8'(req_k[i-2])); else passed++;
        end
      end
      pixel_req = (i < 8) ? pat[i] : 1'b0;
      #1;
      if (pixel_req) begin
        req_k[i] = k;
        checks++; if (linebuf_rdidx !== 10'(k)) $display("FAIL gaps_rdidx[%0d]: got %0d expected %0d", i, linebuf_rdidx, k); else passed++;
        k++;
      end
    end
    pixel_req = 1'b0;
  endtask

  task automatic test_reset_midline();
    logic [7:0] exp_r [0:4];
    exp_r[0] = 8'h03; exp_r[1] = 8'h80; exp_r[2] = 8'h00; exp_r[3] = 8'h00; exp_r[4] = 8'hA0;
    reg_write(3'd0, 8'h01);
    reg_write(3'd1, 8'h81);
    reg_write(3'd2, 8'h33);
    reg_write(3'd3, 8'h01);
    reg_write(3'd4, 8'h90);
    sol_pulse();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      pixel_req = 1'b1;
    end
    @(negedge clk);
    checks++; if (pix_valid !== 1'b1) $display("FAIL midline_pre_vld: got %b expected 1", pix_valid); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (pix_valid !== 1'b0) $display("FAIL midline_rst_vld: got %b expected 0", pix_valid); else passed++;
    checks++; if (pix_idx !== 8'h00) $display("FAIL midline_rst_pix: got %h expected 00", pix_idx); else passed++;
    checks++; if (linebuf_rdidx !== 10'd0) $display("FAIL midline_rst_rdidx: got %0d expected 0", linebuf_rdidx); else passed++;
    for (int a = 0; a < 5; a++) begin
      regs_addr = 3'(a);
      #1;
      checks++; if (regs_rddata !== exp_r[a]) $display("FAIL midline_reg[%0d]: got %h expected %h", a, regs_rddata, exp_r[a]); else passed++;
    end
    @(negedge clk);
    pixel_req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (pix_valid !== 1'b0) $display("FAIL midline_post_vld[%0d]: got %b expected 0", i, pix_valid); else passed++;
    end
  endtask

  initial begin
    rst           = 1'b1;
    start_of_line = 1'b0;
    pixel_req     = 1'b0;
    regs_addr     = 3'd0;
    regs_wrdata   = 8'h00;
    regs_write    = 1'b0;
    l1_idx_mode   = 1'b1;
    l1_val        = 8'h00;
    l2_val        = 8'h00;
    tail_vld      = 1'b0;

    test_reset();
    test_defaults();
    test_priority();
    test_border();
    test_scaling();
    test_coincident();
    test_gaps();
    test_reset_midline();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
